// File: rtl/vl_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// Vectors are handled in a fixed 32-bit container so the helpers work for
// any arbiter width from 2 to 32.
package vl_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Rotate the low w bits of v left by sh positions; bits at and above w are zero.
    function automatic logic [31:0] rotate_left(input logic [31:0] v,
                                                input int unsigned sh,
                                                input int unsigned w);
        logic [31:0] r;
        logic [4:0]  pos;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w) begin
                pos = 5'((i + sh) % w);
                r   = r | (32'(v[i[4:0]]) << pos);
            end
        end
        return r;
    endfunction

    // Binary index of a one-hot vector; an all-zero vector maps to 0.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i[4:0]]) idx = idx | i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/vl_rr_pick.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping from WIDTH-1 back to 0. Output is one-hot, or zero with no requests.
module vl_rr_pick
    import vl_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDXW-1:0]  ptr_i,
    output logic [WIDTH-1:0] pick_o
);

    logic [31:0] rot;
    logic [31:0] low;
    logic [31:0] back;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot    = rotate_left(32'(req_i), (WIDTH - 32'(ptr_i)) % WIDTH, WIDTH);
        low    = rot & (~rot + 32'd1);
        back   = rotate_left(low, 32'(ptr_i), WIDTH);
        pick_o = back[WIDTH-1:0];
    end

endmodule

// File: rtl/vl_rr_onehot_arbiter.sv
// Registered round-robin arbiter with hold timeout. One grant at a time,
// always followed by one dead cycle before the next grant.
// Optional build macro VL_RR_ARB_ONEHOT_CHECK_EN adds a sticky onehot_err
// output that flags a grant vector that is not one-hot/zero or disagrees
// with gnt_valid.
module vl_rr_onehot_arbiter
    import vl_arb_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDXW-1:0]  gnt_idx,
    output logic             preempt
`ifdef VL_RR_ARB_ONEHOT_CHECK_EN
    ,
    output logic             onehot_err
`endif
);

    // Hold counter only needs to reach MAX_HOLD-1; it saturates at all-ones.
    localparam int              HCW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HCW-1:0]  HOLD_LAST  = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

    arb_state_e       state_q,     state_d;
    logic [IDXW-1:0]  ptr_q,       ptr_d;
    logic [HCW-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [WIDTH-1:0] gnt_q,       gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDXW-1:0]  gnt_idx_q,   gnt_idx_d;
    logic             preempt_q,   preempt_d;

    logic [WIDTH-1:0] pick;
    logic             owner_req;
    logic [IDXW-1:0]  ptr_after;

    vl_rr_pick #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    assign owner_req = |(req & gnt_q);
    assign ptr_after = (gnt_idx_q == IDXW'(WIDTH - 1)) ? '0 : gnt_idx_q + 1'b1;

    // Next-state logic: grant from IDLE, release or time out from GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        preempt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = pick;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = IDXW'(onehot_to_idx(32'(pick)));
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Release wins over a timeout landing in the same cycle.
                if (!owner_req || (TIMEOUT_EN && hold_cnt_q == HOLD_LAST)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    ptr_d       = ptr_after;
                    preempt_d   = owner_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign preempt   = preempt_q;

`ifdef VL_RR_ARB_ONEHOT_CHECK_EN
    logic [5:0] gnt_ones;
    logic       onehot_err_q;

    // Count set grant bits the same way the downstream detector does.
    always_comb begin
        gnt_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gnt_ones = gnt_ones + 6'(gnt_q[i]);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            onehot_err_q <= 1'b0;
        end else if ((gnt_ones > 6'd1) || (gnt_valid_q != |gnt_q)) begin
            onehot_err_q <= 1'b1;
        end
    end

    assign onehot_err = onehot_err_q;
`endif

endmodule

// File: tb/tb_vl_rr_onehot_arbiter.sv
// Self-checking bench for vl_rr_onehot_arbiter: directed scenarios plus a
// long random request sequence, all compared against a behavioural model.
module tb_vl_rr_onehot_arbiter;

    localparam int W  = 4;
    localparam int MH = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] req;
    logic [W-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;
    logic         preempt;
`ifdef VL_RR_ARB_ONEHOT_CHECK_EN
    logic         onehot_err;
`endif

    int n_tests;
    int n_fail;

    // Behavioural model: who holds the grant, for how long, where to search next.
    bit m_idle;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_pre;

    vl_rr_onehot_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .preempt   (preempt)
`ifdef VL_RR_ARB_ONEHOT_CHECK_EN
        ,
        .onehot_err(onehot_err)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_idx  = 0;
        m_ptr  = 0;
        m_hold = 0;
        m_pre  = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the sampled request.
    task automatic model_step(input logic [W-1:0] r);
        bit found;
        m_pre = 1'b0;
        if (m_idle) begin
            found = 1'b0;
            for (int k = 0; k < W; k++) begin
                int j;
                j = (m_ptr + k) % W;
                if (!found && r[j]) begin
                    found  = 1'b1;
                    m_idx  = j;
                end
            end
            if (found) begin
                m_idle = 1'b0;
                m_hold = 0;
            end
        end else if (!r[m_idx]) begin
            m_ptr  = (m_idx + 1) % W;
            m_idle = 1'b1;
        end else if (MH != 0 && m_hold == MH - 1) begin
            m_ptr  = (m_idx + 1) % W;
            m_idle = 1'b1;
            m_pre  = 1'b1;
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] e_gnt;
        e_gnt = m_idle ? '0 : (W'(1) << m_idx);
        check("gnt",       32'(gnt),       32'(e_gnt));
        check("gnt_valid", 32'(gnt_valid), 32'(!m_idle));
        check("gnt_idx",   32'(gnt_idx),   m_idle ? 32'd0 : 32'(m_idx));
        check("preempt",   32'(preempt),   32'(m_pre));
        check("popcnt_le1", 32'($countones(gnt) <= 1), 32'd1);
`ifdef VL_RR_ARB_ONEHOT_CHECK_EN
        check("onehot_err", 32'(onehot_err), 32'd0);
`endif
    endtask

    // Drive one request value for one cycle; called and returning at negedge.
    task automatic cycle(input logic [W-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [W-1:0] r;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_all();
        check("rst_gnt", 32'(gnt), 32'd0);

        // Idle requests keep everything at zero.
        for (int i = 0; i < 5; i++) cycle(4'b0000);

        // Two requesters: lowest at/after ptr 0 first, then the other after a dead cycle.
        cycle(4'b1010);
        check("dir_1010_gnt", 32'(gnt), 32'h2);
        check("dir_1010_idx", 32'(gnt_idx), 32'd1);
        cycle(4'b1000);
        check("dir_dead", 32'(gnt), 32'h0);
        cycle(4'b1000);
        check("dir_1000_gnt", 32'(gnt), 32'h8);
        check("dir_1000_idx", 32'(gnt_idx), 32'd3);
        cycle(4'b0000);

        // Rotation with all requesting: 0,1,2,3,0 with a dead cycle in between.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int g = 0; g < 5; g++) begin
            cycle(4'b1111);
            check("rr_order", 32'(gnt_idx), 32'(order[g]));
            cycle(4'b1111);
            check("rr_hold", 32'(gnt), 32'(4'b0001 << order[g]));
            cycle(4'b1111 & ~(4'b0001 << order[g]));
            check("rr_gap", 32'(gnt), 32'h0);
        end
        cycle(4'b0000);

        // Timeout: 16 granted cycles, a preempt cycle, then the grant again.
        for (int i = 0; i < MH; i++) begin
            cycle(4'b0100);
            check("to_held", 32'(gnt), 32'h4);
        end
        cycle(4'b0100);
        check("to_gnt_zero", 32'(gnt), 32'h0);
        check("to_preempt", 32'(preempt), 32'd1);
        cycle(4'b0100);
        check("to_regrant", 32'(gnt), 32'h4);
        check("to_pre_clr", 32'(preempt), 32'd0);
        cycle(4'b0000);
        cycle(4'b0000);

        // Asynchronous reset in the middle of a grant.
        cycle(4'b0001);
        check("ar_pre_gnt", 32'(gnt), 32'h1);
        reset = 1'b1;
        #1;
        check("ar_gnt", 32'(gnt), 32'h0);
        check("ar_valid", 32'(gnt_valid), 32'd0);
        check("ar_idx", 32'(gnt_idx), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b0011);
        check("ar_ptr0", 32'(gnt), 32'h1);

        // Random request streams with long stable stretches so timeouts occur.
        r = 4'(($urandom_range(0, 15)));
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
